wave_crossfade_selector: RTL and testbench

//  Parametrised, registered successor to the combinational waveform selector.

---
 rtl/wave_crossfade_selector.sv | 181 ++++++++++++++++++
 tb/tb_wave_crossfade_selector.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_crossfade_selector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wave_crossfade_selector                                      |
// | Description : Registered waveform channel selector. Picks one of NUM_CH    |
// |               packed generator channels and drives it to the DAC path.     |
// |               Channel changes take effect only on sample strobes, as a     |
// |               linear crossfade over 2^FADE_LOG2 samples.                   |
// | Ports       : clk        - system clock, rising edge                       |
// |               rst        - synchronous reset, active-high                  |
// |               sample_en  - one-cycle sample strobe                         |
// |               waves_in   - packed channels, ch i = [i*WIDTH +: WIDTH]      |
// |               select     - requested channel (level)                       |
// |               wave_out   - registered output sample                        |
// |               active_sel - channel currently fully selected                |
// |               busy       - high while a crossfade is in progress           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wave_crossfade_selector #(
    parameter int WIDTH      = 8,
    parameter int NUM_CH     = 7,
    parameter int SEL_W      = 3,
    parameter int DEFAULT_CH = 3,
    parameter int FADE_LOG2  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [NUM_CH*WIDTH-1:0] waves_in,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        wave_out,
    output logic [SEL_W-1:0]        active_sel,
    output logic                    busy
);

    localparam int c_KW = FADE_LOG2 + 1;
    localparam int c_PW = WIDTH + FADE_LOG2 + 1;

    localparam logic [c_KW-1:0]  c_N          = c_KW'(1 << FADE_LOG2);
    localparam logic [SEL_W:0]   c_NUM_CH     = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] c_DEFAULT_CH = SEL_W'(DEFAULT_CH);

    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_FADE = 2'b01;

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    logic [1:0]       r_state,  w_state_nxt;
    logic [c_KW-1:0]  r_k,      w_k_nxt;
    logic [SEL_W-1:0] r_target, w_target_nxt;
    logic [SEL_W-1:0] r_active, w_active_nxt;
    logic [WIDTH-1:0] r_wave,   w_wave_nxt;
    logic             r_busy,   w_busy_nxt;

    // ------------------------------------------------------------------
    // Channel unpacking and selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_ch [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_ch[gi] = waves_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [SEL_W-1:0] w_eff_sel;
    logic [WIDTH-1:0] w_ch_active;
    logic [WIDTH-1:0] w_ch_target;

    // Out-of-range requests fall back to the default channel.
    assign w_eff_sel   = ({1'b0, select} < c_NUM_CH) ? select : c_DEFAULT_CH;
    // active/target only ever hold in-range channel numbers.
    assign w_ch_active = w_ch[r_active];
    assign w_ch_target = w_ch[r_target];

    // ------------------------------------------------------------------
    // Crossfade mix for the step the next strobe lands on (k+1)
    // ------------------------------------------------------------------
    logic [c_KW-1:0]  w_k_inc;
    logic [c_PW-1:0]  w_prod_a;
    logic [c_PW-1:0]  w_prod_b;
    logic [c_PW-1:0]  w_sum;
    logic [WIDTH-1:0] w_mix;

    assign w_k_inc  = r_k + c_KW'(1);
    // In FADE w_k_inc never exceeds N, so N-k does not wrap.
    assign w_prod_a = c_PW'(c_N - w_k_inc) * c_PW'(w_ch_active);
    assign w_prod_b = c_PW'(w_k_inc) * c_PW'(w_ch_target);
    assign w_sum    = w_prod_a + w_prod_b;
    // Weights sum to N, so the scaled result always fits WIDTH.
    assign w_mix    = WIDTH'(w_sum >> FADE_LOG2);

    // ------------------------------------------------------------------
    // State register: everything advances only on a sample strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_k      <= '0;
            r_target <= c_DEFAULT_CH;
            r_active <= c_DEFAULT_CH;
            r_wave   <= '0;
            r_busy   <= 1'b0;
        end else if (sample_en) begin
            r_state  <= w_state_nxt;
            r_k      <= w_k_nxt;
            r_target <= w_target_nxt;
            r_active <= w_active_nxt;
            r_wave   <= w_wave_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE: begin
                if (w_eff_sel != r_active) begin
                    w_state_nxt = c_ST_FADE;
                end
            end
            c_ST_FADE: begin
                // select is deliberately ignored here; no request is queued.
                if (w_k_inc == c_N) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_state_nxt = c_ST_FADE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_k_nxt      = r_k;
        w_target_nxt = r_target;
        w_active_nxt = r_active;
        w_wave_nxt   = r_wave;
        w_busy_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // The detecting strobe still emits the old channel.
                w_wave_nxt = w_ch_active;
                if (w_eff_sel != r_active) begin
                    w_target_nxt = w_eff_sel;
                    w_k_nxt      = '0;
                    w_busy_nxt   = 1'b1;
                end
            end
            c_ST_FADE: begin
                w_k_nxt = w_k_inc;
                if (w_k_inc == c_N) begin
                    // Final step lands exactly on the target channel.
                    w_wave_nxt   = w_ch_target;
                    w_active_nxt = r_target;
                    w_busy_nxt   = 1'b0;
                end else begin
                    w_wave_nxt = w_mix;
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_k_nxt    = '0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign wave_out   = r_wave;
    assign active_sel = r_active;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wave_crossfade_selector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wave_crossfade_selector                                   |
// | Description : Directed self-checking bench for wave_crossfade_selector     |
// |               (WIDTH=8, NUM_CH=7, DEFAULT_CH=3, FADE_LOG2=2). Expected     |
// |               samples are queued when a strobe is driven and compared      |
// |               after the DUT registers its output.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wave_crossfade_selector;

    localparam int c_WIDTH  = 8;
    localparam int c_NUM_CH = 7;
    localparam int c_SEL_W  = 3;

    logic                        clk;
    logic                        rst;
    logic                        sample_en;
    logic [c_NUM_CH*c_WIDTH-1:0] waves_in;
    logic [c_SEL_W-1:0]          select;
    logic [c_WIDTH-1:0]          wave_out;
    logic [c_SEL_W-1:0]          active_sel;
    logic                        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] wave;
        logic [2:0] act;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    wave_crossfade_selector #(
        .WIDTH      (8),
        .NUM_CH     (7),
        .SEL_W      (3),
        .DEFAULT_CH (3),
        .FADE_LOG2  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .waves_in   (waves_in),
        .select     (select),
        .wave_out   (wave_out),
        .active_sel (active_sel),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic set_ch(input int idx, input logic [7:0] v);
        waves_in[idx*c_WIDTH +: c_WIDTH] = v;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] ew,
                            input logic [2:0] ea, input logic eb);
        exp_t e;
        e.tag  = tag;
        e.wave = ew;
        e.act  = ea;
        e.busy = eb;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (wave_out === e.wave) else begin
                errors++;
                $error("FAIL %s wave_out observed=%h expected=%h", e.tag, wave_out, e.wave);
            end
            checks++;
            assert (active_sel === e.act) else begin
                errors++;
                $error("FAIL %s active_sel observed=%0d expected=%0d", e.tag, active_sel, e.act);
            end
            checks++;
            assert (busy === e.busy) else begin
                errors++;
                $error("FAIL %s busy observed=%b expected=%b", e.tag, busy, e.busy);
            end
        end
    endtask

    // One sample strobe; the expectation is queued as the strobe is driven.
    task automatic strobe(input string tag, input logic [7:0] ew,
                          input logic [2:0] ea, input logic eb);
        @(negedge clk);
        sample_en = 1'b1;
        push_exp(tag, ew, ea, eb);
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        compare_front();
    endtask

    initial begin
        rst       = 1'b0;
        sample_en = 1'b0;
        waves_in  = '0;
        select    = 3'd3;
        set_ch(3, 8'h55);

        // 1: reset for two cycles while strobing; reset must win.
        @(negedge clk);
        rst       = 1'b1;
        sample_en = 1'b1;
        push_exp("reset", 8'h00, 3'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        sample_en = 1'b0;
        compare_front();

        // 2: steady state on the default channel.
        set_ch(3, 8'h80);
        strobe("steady", 8'h80, 3'd3, 1'b0);

        // Move to channel 1 (fade 3->1).
        set_ch(1, 8'h00);
        set_ch(2, 8'hFF);
        select = 3'd1;
        strobe("f31_s1", 8'h80, 3'd3, 1'b1);
        strobe("f31_s2", 8'h60, 3'd3, 1'b1);
        strobe("f31_s3", 8'h40, 3'd3, 1'b1);
        strobe("f31_s4", 8'h20, 3'd3, 1'b1);
        strobe("f31_s5", 8'h00, 3'd1, 1'b0);

        // 3: fade 1->2.
        select = 3'd2;
        strobe("f12_s1", 8'h00, 3'd1, 1'b1);
        strobe("f12_s2", 8'h3F, 3'd1, 1'b1);
        strobe("f12_s3", 8'h7F, 3'd1, 1'b1);
        strobe("f12_s4", 8'hBF, 3'd1, 1'b1);
        strobe("f12_s5", 8'hFF, 3'd2, 1'b0);

        // Back to channel 3 (fade 2->3).
        select = 3'd3;
        strobe("f23_s1", 8'hFF, 3'd2, 1'b1);
        strobe("f23_s2", 8'hDF, 3'd2, 1'b1);
        strobe("f23_s3", 8'hBF, 3'd2, 1'b1);
        strobe("f23_s4", 8'h9F, 3'd2, 1'b1);
        strobe("f23_s5", 8'h80, 3'd3, 1'b0);

        // 4: out-of-range select maps to channel 3, so no fade.
        select = 3'd7;
        strobe("oor_a", 8'h80, 3'd3, 1'b0);
        set_ch(3, 8'h81);
        strobe("oor_b", 8'h81, 3'd3, 1'b0);

        // Go to channel 0, then out-of-range select fades back to 3.
        set_ch(0, 8'h40);
        select = 3'd0;
        strobe("f30_s1", 8'h81, 3'd3, 1'b1);
        strobe("f30_s2", 8'h70, 3'd3, 1'b1);
        strobe("f30_s3", 8'h60, 3'd3, 1'b1);
        strobe("f30_s4", 8'h50, 3'd3, 1'b1);
        strobe("f30_s5", 8'h40, 3'd0, 1'b0);
        select = 3'd7;
        strobe("oor_f03_s1", 8'h40, 3'd0, 1'b1);
        strobe("oor_f03_s2", 8'h50, 3'd0, 1'b1);
        strobe("oor_f03_s3", 8'h60, 3'd0, 1'b1);
        strobe("oor_f03_s4", 8'h70, 3'd0, 1'b1);
        strobe("oor_f03_s5", 8'h81, 3'd3, 1'b0);

        // 5: mid-fade select change is ignored until the fade completes.
        select = 3'd1;
        strobe("m31_s1", 8'h81, 3'd3, 1'b1);
        strobe("m31_s2", 8'h60, 3'd3, 1'b1);
        strobe("m31_s3", 8'h40, 3'd3, 1'b1);
        strobe("m31_s4", 8'h20, 3'd3, 1'b1);
        strobe("m31_s5", 8'h00, 3'd1, 1'b0);
        set_ch(5, 8'h10);
        select = 3'd2;
        strobe("m12_s1", 8'h00, 3'd1, 1'b1);
        strobe("m12_s2", 8'h3F, 3'd1, 1'b1);
        select = 3'd5;
        strobe("m12_s3", 8'h7F, 3'd1, 1'b1);
        strobe("m12_s4", 8'hBF, 3'd1, 1'b1);
        strobe("m12_s5", 8'hFF, 3'd2, 1'b0);
        strobe("f25_s1", 8'hFF, 3'd2, 1'b1);
        strobe("f25_s2", 8'hC3, 3'd2, 1'b1);
        strobe("f25_s3", 8'h87, 3'd2, 1'b1);
        strobe("f25_s4", 8'h4B, 3'd2, 1'b1);
        strobe("f25_s5", 8'h10, 3'd5, 1'b0);

        // 6: strobe gap mid-fade holds everything, including k.
        select = 3'd2;
        strobe("g52_s1", 8'h10, 3'd5, 1'b1);
        strobe("g52_s2", 8'h4B, 3'd5, 1'b1);
        select = 3'd0;
        push_exp("gap_hold", 8'h4B, 3'd5, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        compare_front();
        strobe("g52_s3", 8'h87, 3'd5, 1'b1);

        // Reset in the middle of the fade.
        @(negedge clk);
        rst = 1'b1;
        push_exp("rst_mid", 8'h00, 3'd3, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_front();
        select = 3'd3;
        strobe("post_rst", 8'h81, 3'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
